// File: rtl/main_memory_responder.sv
// Memory-side responder: accepts one strobed request, waits WAIT_CYCLES,
// then commits a write or returns read data with a one-cycle MReady pulse.
module main_memory_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              Busy,
    output logic              Overrun
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_rw_q, req_rw_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              overrun_q, overrun_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_rw_d   = req_rw_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        dout_d     = dout_q;
        overrun_d  = overrun_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (MStrobe) begin
                    req_rw_d   = MRW;
                    req_addr_d = MAddr;
                    req_data_d = MDataIn;
                    cnt_d      = CNT_INIT;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                    if (req_rw_q) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d = mem[req_addr_q];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (MStrobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are flops loaded from next-state so they track state_q exactly.
        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_rw_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            dout_q     <= '0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rw_q   <= req_rw_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            dout_q     <= dout_d;
            overrun_q  <= overrun_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Array is not reset; reset only blocks a commit landing on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[req_addr_q] <= req_data_q;
        end
    end

    assign MDataOut = dout_q;
    assign MReady   = ready_q;
    assign Busy     = busy_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with a request scoreboard and
// a reference copy of the word array.
module tb_main_memory_responder;

    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       MStrobe;
    logic       MRW;
    logic [7:0] MAddr;
    logic [7:0] MDataIn;
    logic [7:0] MDataOut;
    logic       MReady;
    logic       Busy;
    logic       Overrun;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    req_t       exp_q[$];
    logic [7:0] exp_mem [0:255];
    logic [7:0] last_rd;
    int         total = 0;
    int         bad   = 0;
    int         ready_cnt = 0;
    logic       prev_ready = 1'b0;

    main_memory_responder #(
        .ADDR_W(8),
        .DATA_W(8),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MStrobe(MStrobe),
        .MRW(MRW),
        .MAddr(MAddr),
        .MDataIn(MDataIn),
        .MDataOut(MDataOut),
        .MReady(MReady),
        .Busy(Busy),
        .Overrun(Overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MReady must never stay high for two consecutive cycles.
    always @(negedge clk) begin
        if (MReady === 1'b1) begin
            ready_cnt++;
            check("ready_twice", {31'd0, prev_ready}, 32'd0);
        end
        prev_ready = (MReady === 1'b1);
    end

    task automatic start_req(input logic rw, input logic [7:0] addr, input logic [7:0] data);
        req_t r;
        MStrobe = 1'b1;
        MRW     = rw;
        MAddr   = addr;
        MDataIn = data;
        r.rw = rw; r.addr = addr; r.data = data;
        exp_q.push_back(r);
        @(posedge clk); #1;
        MStrobe = 1'b0;
        MRW     = ~rw;
        MAddr   = ~addr;
        MDataIn = ~data;
        check("busy_after_accept", {31'd0, Busy}, 32'd1);
    endtask

    task automatic wait_ready(input int exp_lat);
        int   n;
        req_t r;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (MReady === 1'b1) break;
            check("busy_in_access", {31'd0, Busy}, 32'd1);
            if (n > 50) begin
                check("ready_timeout", {31'd0, MReady}, 32'd1);
                return;
            end
        end
        check("latency", n, exp_lat);
        check("busy_in_done", {31'd0, Busy}, 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            r = exp_q.pop_front();
            if (r.rw) begin
                exp_mem[r.addr] = r.data;
                check("dout_held_on_write", {24'd0, MDataOut}, {24'd0, last_rd});
            end else begin
                check("read_data", {24'd0, MDataOut}, {24'd0, exp_mem[r.addr]});
                last_rd = exp_mem[r.addr];
            end
        end
        @(posedge clk); #1;
        check("ready_low_after", {31'd0, MReady}, 32'd0);
        check("idle_after_done", {31'd0, Busy}, 32'd0);
    endtask

    task automatic do_req(input logic rw, input logic [7:0] addr, input logic [7:0] data);
        start_req(rw, addr, data);
        wait_ready(W);
    endtask

    initial begin
        int rc0;
        reset   = 1'b1;
        MStrobe = 1'b0;
        MRW     = 1'b0;
        MAddr   = '0;
        MDataIn = '0;
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, MReady}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_overrun", {31'd0, Overrun}, 32'd0);
        check("rst_dout", {24'd0, MDataOut}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic write then read, with latency and Busy window checked inside.
        rc0 = ready_cnt;
        do_req(1'b1, 8'h10, 8'hA5);
        do_req(1'b0, 8'h10, 8'h00);
        check("t1_pulses", ready_cnt - rc0, 2);

        // Strobe during ACCESS is ignored and flags Overrun.
        rc0 = ready_cnt;
        start_req(1'b1, 8'h20, 8'h3C);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20; MDataIn = 8'hFF;
        @(posedge clk); #1;
        MStrobe = 1'b0;
        check("t3_overrun", {31'd0, Overrun}, 32'd1);
        wait_ready(W - 1);
        do_req(1'b0, 8'h20, 8'h00);
        check("t3_pulses", ready_cnt - rc0, 2);
        check("t3_overrun_sticky", {31'd0, Overrun}, 32'd1);

        // Reset mid-ACCESS aborts the pending write.
        do_req(1'b1, 8'h05, 8'h11);
        start_req(1'b1, 8'h05, 8'h99);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        last_rd = '0;
        check("t4_busy", {31'd0, Busy}, 32'd0);
        check("t4_overrun", {31'd0, Overrun}, 32'd0);
        check("t4_ready", {31'd0, MReady}, 32'd0);
        check("t4_dout", {24'd0, MDataOut}, 32'd0);
        repeat (W + 2) @(posedge clk);
        #1;
        check("t4_no_ready", {31'd0, MReady}, 32'd0);
        do_req(1'b0, 8'h05, 8'h00);

        // Boundary addresses.
        do_req(1'b1, 8'h00, 8'h01);
        do_req(1'b1, 8'hFF, 8'h80);
        do_req(1'b0, 8'h00, 8'h00);
        do_req(1'b0, 8'hFF, 8'h00);
        do_req(1'b0, 8'h00, 8'h00);

        // Back-to-back: second strobe lands in the IDLE cycle right after DONE.
        do_req(1'b1, 8'h42, 8'h5A);
        start_req(1'b0, 8'h42, 8'h00);
        check("t6_no_overrun", {31'd0, Overrun}, 32'd0);
        wait_ready(W);
        check("t6_no_overrun_end", {31'd0, Overrun}, 32'd0);
        do_req(1'b0, 8'h10, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
